// File: rtl/ram2_responder_if.sv
// RAM2 strobe/address bundle: active-low EN/OE/WE plus the shared address.
// The bidirectional data bus stays a plain inout on the responder.
interface ram2_responder_if #(
    parameter int unsigned ADDR_W = 18
) ();
    logic [ADDR_W-1:0] RamAddr;
    logic              RamOE;
    logic              RamWE;
    logic              RamEN;

    modport master (output RamAddr, output RamOE, output RamWE, output RamEN);
    modport slave  (input  RamAddr, input  RamOE, input  RamWE, input  RamEN);
endinterface

// File: rtl/ram2_responder.sv
// On-chip stand-in for the external RAM2 SRAM: samples the strobes, answers reads and commits writes
// into a block-RAM array. Optional write-protect window enabled by defining RAM2_RESP_WP_EN.
module ram2_responder #(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    ram2_responder_if.slave     bus,
    inout  wire  [DATA_W-1:0]   RamData,
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count,
    output logic                oob_err,
    output logic                conflict_err
`ifdef RAM2_RESP_WP_EN
    ,
    input  logic [ADDR_W-1:0]   wp_base,
    input  logic [ADDR_W-1:0]   wp_limit,
    output logic                wp_hit
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LAT_W = 3;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_WAIT   = 3'd1,
        RD_DRIVE  = 3'd2,
        WR_LOW    = 3'd3,
        WR_COMMIT = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                s_en_q, s_oe_q, s_we_q;
    logic [ADDR_W-1:0]   s_addr_q;
    logic [DATA_W-1:0]   s_data_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [CNT_W-1:0]    rd_count_q, rd_count_d;
    logic [CNT_W-1:0]    wr_count_q, wr_count_d;
    logic                oob_q, oob_d;
    logic                conflict_q, conflict_d;
    logic                mem_we;
    logic                addr_in_range;
    logic                drive_en;
    logic [DATA_W-1:0]   mem_q [DEPTH];

`ifdef RAM2_RESP_WP_EN
    logic                wp_hit_q, wp_hit_d;
    logic                wp_block;

    assign wp_block = (addr_q >= wp_base) && (addr_q <= wp_limit);
    assign wp_hit   = wp_hit_q;
`endif

    // Every decision works on these once-per-clk copies of the pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_en_q   <= 1'b1;
            s_oe_q   <= 1'b1;
            s_we_q   <= 1'b1;
            s_addr_q <= '0;
            s_data_q <= '0;
        end else begin
            s_en_q   <= bus.RamEN;
            s_oe_q   <= bus.RamOE;
            s_we_q   <= bus.RamWE;
            s_addr_q <= bus.RamAddr;
            s_data_q <= RamData;
        end
    end

    assign addr_in_range = (addr_q >> DEPTH_LOG2) == '0;

    // The bus is only ever driven from RD_DRIVE with a clean read strobe set.
    assign drive_en = (state_q == RD_DRIVE) && !s_en_q && !s_oe_q && s_we_q;
    assign RamData  = drive_en ? rd_data_q : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            lat_q      <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            oob_q      <= 1'b0;
            conflict_q <= 1'b0;
`ifdef RAM2_RESP_WP_EN
            wp_hit_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            lat_q      <= lat_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            oob_q      <= oob_d;
            conflict_q <= conflict_d;
`ifdef RAM2_RESP_WP_EN
            wp_hit_q   <= wp_hit_d;
`endif
        end
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        lat_d      = lat_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        oob_d      = oob_q;
        conflict_d = conflict_q;
        mem_we     = 1'b0;
`ifdef RAM2_RESP_WP_EN
        wp_hit_d   = wp_hit_q;
`endif

        case (state_q)
            IDLE: begin
                if (!s_en_q) begin
                    if (!s_oe_q && !s_we_q) begin
                        conflict_d = 1'b1;
                    end else if (!s_we_q) begin
                        state_d = WR_LOW;
                        addr_d  = s_addr_q;
                        wdata_d = s_data_q;
                    end else if (!s_oe_q) begin
                        state_d = RD_WAIT;
                        lat_d   = LAT_W'(READ_LAT - 1);
                        addr_d  = s_addr_q;
                    end
                end
            end

            RD_WAIT: begin
                if (lat_q == '0) begin
                    state_d = RD_DRIVE;
                    if (addr_in_range) begin
                        rd_data_d = mem_q[addr_q[DEPTH_LOG2-1:0]];
                    end else begin
                        rd_data_d = '0;
                        oob_d     = 1'b1;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end

            // A write strobe during a read is a protocol conflict, not a completed read.
            RD_DRIVE: begin
                if (!s_en_q && !s_oe_q && !s_we_q) begin
                    conflict_d = 1'b1;
                    state_d    = IDLE;
                end else if (s_en_q || s_oe_q) begin
                    rd_count_d = rd_count_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end

            // Keep tracking address/data until WE rises; the last sample with WE low wins.
            WR_LOW: begin
                if (s_en_q) begin
                    state_d = IDLE;
                end else if (s_we_q) begin
                    state_d = WR_COMMIT;
                end else begin
                    addr_d  = s_addr_q;
                    wdata_d = s_data_q;
                end
            end

            WR_COMMIT: begin
                state_d = IDLE;
                if (!addr_in_range) begin
                    oob_d = 1'b1;
                end
`ifdef RAM2_RESP_WP_EN
                else if (wp_block) begin
                    wp_hit_d = 1'b1;
                end
`endif
                else begin
                    mem_we     = 1'b1;
                    wr_count_d = wr_count_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_count     = rd_count_q;
    assign wr_count     = wr_count_q;
    assign oob_err      = oob_q;
    assign conflict_err = conflict_q;

endmodule

// File: tb/tb_ram2_responder.sv
// Directed self-checking bench for ram2_responder (default parameters, READ_LAT=1).
// Define RAM2_RESP_WP_EN to also exercise the write-protect window.
`timescale 1ns/1ps
module tb_ram2_responder;

    localparam int READ_LAT = 1;
    localparam int RD_VALID = READ_LAT + 2;

    logic        clk;
    logic        rst;
    logic        tb_drv;
    logic [15:0] tb_data;
    wire  [15:0] RamData;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic        oob_err;
    logic        conflict_err;
    int          n_checks;
    int          n_pass;
`ifdef RAM2_RESP_WP_EN
    logic [17:0] wp_base;
    logic [17:0] wp_limit;
    logic        wp_hit;
`endif

    ram2_responder_if #(.ADDR_W(18)) bus ();

    assign RamData = tb_drv ? tb_data : 16'hzzzz;

    ram2_responder #(
        .ADDR_W    (18),
        .DATA_W    (16),
        .DEPTH_LOG2(10),
        .READ_LAT  (READ_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .RamData     (RamData),
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .oob_err     (oob_err),
        .conflict_err(conflict_err)
`ifdef RAM2_RESP_WP_EN
        ,
        .wp_base     (wp_base),
        .wp_limit    (wp_limit),
        .wp_hit      (wp_hit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.RamEN = 1'b1;
        bus.RamOE = 1'b1;
        bus.RamWE = 1'b1;
        tb_drv    = 1'b0;
    endtask

    // WE low for n_low cycles; data switches from d1 to d2 halfway through.
    task automatic wr(input logic [17:0] a, input logic [15:0] d1, input logic [15:0] d2, input int n_low);
        bus.RamAddr = a;
        tb_data     = d1;
        tb_drv      = 1'b1;
        bus.RamEN   = 1'b0;
        bus.RamOE   = 1'b1;
        bus.RamWE   = 1'b0;
        for (int i = 0; i < n_low; i++) begin
            if (i == n_low / 2) tb_data = d2;
            tick();
        end
        bus.RamWE = 1'b1;
        tick();
        idle_bus();
        repeat (3) tick();
    endtask

    // OE low for n_low cycles; data must appear exactly RD_VALID cycles after OE falls.
    task automatic rd(input logic [17:0] a, input int n_low, input logic [15:0] exp, input string tag);
        bus.RamAddr = a;
        tb_drv      = 1'b0;
        bus.RamEN   = 1'b0;
        bus.RamOE   = 1'b0;
        bus.RamWE   = 1'b1;
        for (int i = 1; i <= n_low; i++) begin
            tick();
            if (i == RD_VALID - 1) chk({tag, "_early"}, 32'(dut.drive_en), 32'd0);
            if (i == RD_VALID)     chk({tag, "_first"}, 32'(RamData), 32'(exp));
            if (i == n_low)        chk({tag, "_last"}, 32'(RamData), 32'(exp));
        end
        idle_bus();
        tick();
        chk({tag, "_rel"}, 32'(dut.drive_en), 32'd0);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        tb_data  = 16'h0000;
        bus.RamAddr = 18'h0;
        idle_bus();
`ifdef RAM2_RESP_WP_EN
        wp_base  = 18'h00300;
        wp_limit = 18'h002FF;
`endif
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_oob", 32'(oob_err), 32'd0);
        chk("rst_conflict", 32'(conflict_err), 32'd0);
        chk("rst_drive", 32'(dut.drive_en), 32'd0);
`ifdef RAM2_RESP_WP_EN
        chk("rst_wp_hit", 32'(wp_hit), 32'd0);
`endif
        rst = 1'b1;
        repeat (2) tick();

        // Basic write then read
        wr(18'h00010, 16'hBEEF, 16'hBEEF, 4);
        chk("wr1_count", 32'(wr_count), 32'd1);
        rd(18'h00010, 6, 16'hBEEF, "rd1");
        chk("rd1_count", 32'(rd_count), 32'd1);

        // Data changes while WE is low: last value wins
        wr(18'h00005, 16'h1111, 16'h2222, 4);
        rd(18'h00005, 4, 16'h2222, "rd_last");
        chk("wr2_count", 32'(wr_count), 32'd2);

        // Out-of-range write/read; word 0 holds a marker to expose aliasing
        wr(18'h00000, 16'h7777, 16'h7777, 2);
        chk("wr3_count", 32'(wr_count), 32'd3);
        wr(18'h00400, 16'h5555, 16'h5555, 2);
        chk("oob_wr_count", 32'(wr_count), 32'd3);
        chk("oob_err_set", 32'(oob_err), 32'd1);
        rd(18'h00400, 4, 16'h0000, "rd_oob");
        rd(18'h00000, 4, 16'h7777, "rd_alias");
        chk("rd_count4", 32'(rd_count), 32'd4);

        // OE and WE low together
        bus.RamAddr = 18'h00010;
        bus.RamEN   = 1'b0;
        bus.RamOE   = 1'b0;
        bus.RamWE   = 1'b0;
        repeat (3) tick();
        chk("conf_drive", 32'(dut.drive_en), 32'd0);
        idle_bus();
        repeat (2) tick();
        chk("conf_err", 32'(conflict_err), 32'd1);
        chk("conf_rd_count", 32'(rd_count), 32'd4);
        chk("conf_wr_count", 32'(wr_count), 32'd3);
        rd(18'h00010, 3, 16'hBEEF, "rd_after_conf");
        chk("rd_count5", 32'(rd_count), 32'd5);

        // Reset while driving
        wr(18'h00020, 16'hA5A5, 16'hA5A5, 2);
        bus.RamAddr = 18'h00020;
        bus.RamEN   = 1'b0;
        bus.RamOE   = 1'b0;
        bus.RamWE   = 1'b1;
        repeat (RD_VALID) tick();
        chk("pre_rst_data", 32'(RamData), 32'h0000A5A5);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_drive", 32'(dut.drive_en), 32'd0);
        chk("mid_rst_rd_count", 32'(rd_count), 32'd0);
        chk("mid_rst_wr_count", 32'(wr_count), 32'd0);
        idle_bus();
        #10 rst = 1'b1;
        repeat (2) tick();

        // Write aborted by EN rising while WE is still low
        bus.RamAddr = 18'h00020;
        tb_data     = 16'h1234;
        tb_drv      = 1'b1;
        bus.RamEN   = 1'b0;
        bus.RamWE   = 1'b0;
        repeat (3) tick();
        bus.RamEN = 1'b1;
        tick();
        idle_bus();
        repeat (3) tick();
        chk("abort_wr_count", 32'(wr_count), 32'd0);
        rd(18'h00020, 3, 16'hA5A5, "rd_abort");
        chk("abort_rd_count", 32'(rd_count), 32'd1);

`ifdef RAM2_RESP_WP_EN
        // Window empty (base > limit): write commits
        wr(18'h00150, 16'hCAFE, 16'hCAFE, 2);
        chk("wp_open_wr_count", 32'(wr_count), 32'd1);
        chk("wp_open_hit", 32'(wp_hit), 32'd0);
        wp_base  = 18'h00100;
        wp_limit = 18'h001FF;
        wr(18'h00150, 16'h1234, 16'h1234, 2);
        chk("wp_blk_wr_count", 32'(wr_count), 32'd1);
        chk("wp_blk_hit", 32'(wp_hit), 32'd1);
        rd(18'h00150, 3, 16'hCAFE, "rd_wp_blk");
        wr(18'h00200, 16'hBBBB, 16'hBBBB, 2);
        chk("wp_out_wr_count", 32'(wr_count), 32'd2);
        rd(18'h00200, 3, 16'hBBBB, "rd_wp_out");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
